floating_point_delay_line: RTL and testbench

- Parametrised latency-matching buffer for floating-point datapaths.
- Carries NUM_CHANNELS FP words through LATENCY elastic pipeline stages so side streams stay aligned with arithmetic units of arbitrary depth.
- Adds valid/ready backpressure with bubble collapsing and an occupancy count, replacing fixed two-stage, non-stallable delay buffers.

---
 rtl/floating_point_delay_line.sv | 124 ++++++++++++
 tb/tb_floating_point_delay_line.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/floating_point_delay_line.sv
// ---------------------------------------------------------------------------
// floating_point_delay_line
//
// Latency-matching buffer for floating-point side streams. NUM_CHANNELS FP
// words travel together through LATENCY elastic register stages. Empty
// stages keep filling while the output is stalled, so upstream sees
// backpressure only when every stage holds a beat. Words are carried
// bit-exact. No field of the FP format is interpreted.
//
// Optional feature: define FP_DELAY_LINE_FLUSH_EN to add a synchronous
// flush_i port that discards every in-flight beat.
//
// Parameters:
//   EXP_WIDTH, FRAC_WIDTH  FP field widths (FP_WIDTH = 1+EXP+FRAC)
//   NUM_CHANNELS           FP words per beat
//   LATENCY                register stages (must be >= 1)
//
// Ports:
//   clk_i    in   clock, rising edge
//   rst_ni   in   asynchronous active-low reset
//   flush_i  in   synchronous flush (only with FP_DELAY_LINE_FLUSH_EN)
//   data_i   in   input beat, channel c at [c*FP_WIDTH +: FP_WIDTH]
//   valid_i  in   input beat valid
//   ready_o  out  input beat accepted this cycle when valid_i is high
//   data_o   out  output beat, same packing
//   valid_o  out  output beat valid
//   ready_i  in   downstream accepts the output beat
//   count_o  out  number of occupied stages (0..LATENCY)
// ---------------------------------------------------------------------------
module floating_point_delay_line #(
    parameter int  EXP_WIDTH    = 8,
    parameter int  FRAC_WIDTH   = 23,
    parameter int  NUM_CHANNELS = 1,
    parameter int  LATENCY      = 2,
    localparam int FP_WIDTH     = 1 + EXP_WIDTH + FRAC_WIDTH,
    localparam int CNT_WIDTH    = $clog2(LATENCY + 1)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
`ifdef FP_DELAY_LINE_FLUSH_EN
    input  logic                             flush_i,
`endif
    input  logic [NUM_CHANNELS*FP_WIDTH-1:0] data_i,
    input  logic                             valid_i,
    output logic                             ready_o,
    output logic [NUM_CHANNELS*FP_WIDTH-1:0] data_o,
    output logic                             valid_o,
    input  logic                             ready_i,
    output logic [CNT_WIDTH-1:0]             count_o
);

    localparam int DATA_WIDTH = NUM_CHANNELS * FP_WIDTH;

    if (LATENCY < 1) begin : g_latency_check
        $error("floating_point_delay_line: LATENCY must be >= 1");
    end

    logic [DATA_WIDTH-1:0] r_data_q [LATENCY];
    logic [LATENCY-1:0]    r_valid_q;
    logic [LATENCY-1:0]    w_en;
    logic [CNT_WIDTH-1:0]  w_count;
    logic                  w_flush;

`ifdef FP_DELAY_LINE_FLUSH_EN
    assign w_flush = flush_i;
`else
    assign w_flush = 1'b0;
`endif

    // Stage k may advance when the output is being taken, or when any stage
    // from k to the output is empty (that hole absorbs the shift). The
    // running OR walks from the output stage back toward the input stage.
    always_comb begin
        logic v_open;
        // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        v_open = ready_i;
        w_en   = '0;
        for (int k = LATENCY - 1; k >= 0; k--) begin
            v_open  = v_open | ~r_valid_q[k];
            w_en[k] = v_open;
        end
    end

    // Valid bits are the only state that needs a reset. Flush overrides any
    // advance and empties the whole pipe in one edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid_q <= '0;
        end else if (w_flush) begin
            r_valid_q <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage sample the pre-edge value of its neighbour.
            if (w_en[0]) r_valid_q[0] <= valid_i;
            for (int k = 1; k < LATENCY; k++) begin
                if (w_en[k]) r_valid_q[k] <= r_valid_q[k-1];
            end
        end
    end

    // NOTE: the data stages are not reset; their contents are qualified by r_valid_q, so this stays plain enable-flops.
    always_ff @(posedge clk_i) begin
        if (!w_flush) begin
            if (w_en[0]) r_data_q[0] <= data_i;
            for (int k = 1; k < LATENCY; k++) begin
                if (w_en[k]) r_data_q[k] <= r_data_q[k-1];
            end
        end
    end

    always_comb begin
        w_count = '0;
        for (int k = 0; k < LATENCY; k++) begin
            w_count = w_count + CNT_WIDTH'(r_valid_q[k]);
        end
    end

    // During a flush the incoming beat is taken and dropped, so the
    // upstream side sees ready even if the pipe was full.
    assign ready_o = (w_en[0] | w_flush) & rst_ni;
    assign data_o  = r_data_q[LATENCY-1];
    assign valid_o = r_valid_q[LATENCY-1];
    assign count_o = w_count;

endmodule

// File: tb/tb_floating_point_delay_line.sv
// ---------------------------------------------------------------------------
// tb_floating_point_delay_line
//
// Scoreboard bench for floating_point_delay_line (LATENCY=4, 2 channels of
// binary32). Accepted input beats are pushed into an expected queue. A
// monitor on the falling edge pops and compares every delivered beat. It
// also checks the occupancy count, the ready rule and output stability
// while stalled. Build with FP_DELAY_LINE_FLUSH_EN to exercise flush.
// ---------------------------------------------------------------------------
module tb_floating_point_delay_line;

    localparam int LAT = 4;
    localparam int NCH = 2;
    localparam int DW  = NCH * 32;
    localparam int CW  = $clog2(LAT + 1);

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    logic          clk_i   = 1'b0;
    logic          rst_ni  = 1'b0;
    logic [DW-1:0] data_i  = '0;
    logic          valid_i = 1'b0;
    logic          ready_i = 1'b0;
    logic          flush   = 1'b0;
    logic          ready_o;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic [CW-1:0] count_o;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    logic chk_lat = 1'b0;
    exp_t q[$];

    logic          stall_prev = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    logic [7:0]    lfsr       = 8'hA5;

    floating_point_delay_line #(
        .EXP_WIDTH   (8),
        .FRAC_WIDTH  (23),
        .NUM_CHANNELS(NCH),
        .LATENCY     (LAT)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
`ifdef FP_DELAY_LINE_FLUSH_EN
        .flush_i(flush),
`endif
        .data_i (data_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .data_o (data_o),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples mid-cycle, away from the rising edge.
    always @(negedge clk_i) begin
        exp_t e;
        if (rst_ni) begin
            check("count_o", 64'(count_o), 64'(q.size()));
            check("ready_o", 64'(ready_o), 64'(q.size() < LAT || ready_i || flush));
            if (stall_prev) begin
                check("stall_valid", 64'(valid_o), 64'd1);
                check("stall_data", data_o, prev_data);
            end
            if (valid_o && ready_i) begin
                if (q.size() == 0) begin
                    check("spurious_beat", 64'(valid_o), 64'd0);
                end else begin
                    e = q.pop_front();
                    check("data_o", data_o, e.data);
                    if (chk_lat) check("latency", 64'(cyc - e.cyc), 64'(LAT));
                end
            end
            if (flush) begin
                q.delete();
                stall_prev = 1'b0;
            end else begin
                if (valid_i && ready_o) q.push_back('{data: data_i, cyc: cyc});
                stall_prev = valid_o && !ready_i;
            end
            prev_data = data_o;
        end else begin
            q.delete();
            stall_prev = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [DW-1:0] d, input logic v, input logic r);
        data_i  = d;
        valid_i = v;
        ready_i = r;
        step();
    endtask

    task automatic drain(input int budget);
        valid_i = 1'b0;
        ready_i = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (q.size() == 0) break;
            step();
        end
        step();
        check("drain_empty", 64'(q.size()), 64'd0);
        check("drain_valid_o", 64'(valid_o), 64'd0);
    endtask

    task automatic idle_no_stale(input int n);
        valid_i = 1'b0;
        ready_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            check("no_stale_valid", 64'(valid_o), 64'd0);
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state.
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_valid_o", 64'(valid_o), 64'd0);
        check("rst_count_o", 64'(count_o), 64'd0);
        check("rst_ready_o", 64'(ready_o), 64'd0);
        rst_ni = 1'b1;
        #1;
        check("post_rst_ready_o", 64'(ready_o), 64'd1);
        step();

        // Two back-to-back beats with ready_i held: latency LAT, no gaps.
        chk_lat = 1'b1;
        drive({32'h40000000, 32'h3F800000}, 1'b1, 1'b1);
        drive({32'h40800000, 32'h40400000}, 1'b1, 1'b1);
        drain(20);

        // Stall: four beats fill the pipe, the fifth is refused until
        // ready_i rises, then everything streams out without gaps.
        chk_lat = 1'b0;
        drive({32'hAAAA0001, 32'h0000000A}, 1'b1, 1'b0);
        drive({32'hBBBB0002, 32'h0000000B}, 1'b1, 1'b0);
        drive({32'hCCCC0003, 32'h0000000C}, 1'b1, 1'b0);
        drive({32'hDDDD0004, 32'h0000000D}, 1'b1, 1'b0);
        data_i  = {32'hEEEE0005, 32'h0000000E};
        valid_i = 1'b1;
        ready_i = 1'b0;
        #1;
        check("full_ready_o", 64'(ready_o), 64'd0);
        check("full_count_o", 64'(count_o), 64'd4);
        step();
        check("full_ready_o_hold", 64'(ready_o), 64'd0);
        ready_i = 1'b1;
        #1;
        check("full_ready_o_release", 64'(ready_o), 64'd1);
        for (int i = 0; i < 5; i++) begin
            check("no_gap_valid_o", 64'(valid_o), 64'd1);
            step();
            valid_i = 1'b0;
        end
        drain(20);

        // Sustained streaming: 20 beats, one per cycle.
        chk_lat = 1'b1;
        for (int i = 0; i < 20; i++) begin
            data_i  = {32'h41000000 + 32'(i), 32'hC1000000 + 32'(i)};
            valid_i = 1'b1;
            ready_i = 1'b1;
            #1;
            check("stream_ready_o", 64'(ready_o), 64'd1);
            step();
        end
        drain(20);
        chk_lat = 1'b0;

        // Alternating valid with pseudo-random ready; NaN and denormal payloads.
        for (int i = 0; i < 40; i++) begin
            lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            drive({32'h7FC00001 ^ 32'(i), 32'h00000001 + 32'(i)}, 1'(i % 2 == 0), lfsr[0]);
        end
        drain(30);

        // Reset with two beats in flight.
        drive({32'h12345678, 32'h9ABCDEF0}, 1'b1, 1'b1);
        drive({32'h0FEDCBA9, 32'h87654321}, 1'b1, 1'b1);
        valid_i = 1'b0;
        rst_ni  = 1'b0;
        #1;
        check("midrst_valid_o", 64'(valid_o), 64'd0);
        check("midrst_count_o", 64'(count_o), 64'd0);
        check("midrst_ready_o", 64'(ready_o), 64'd0);
        @(posedge clk_i);
        #3;
        rst_ni = 1'b1;
        #1;
        check("after_rst_ready_o", 64'(ready_o), 64'd1);
        check("after_rst_count_o", 64'(count_o), 64'd0);
        step();
        idle_no_stale(LAT + 3);

`ifdef FP_DELAY_LINE_FLUSH_EN
        // Flush with three stages occupied and a beat on the input.
        drive({32'h11110001, 32'h22220001}, 1'b1, 1'b0);
        drive({32'h11110002, 32'h22220002}, 1'b1, 1'b0);
        drive({32'h11110003, 32'h22220003}, 1'b1, 1'b0);
        check("pre_flush_count_o", 64'(count_o), 64'd3);
        data_i  = {32'h11110004, 32'h22220004};
        valid_i = 1'b1;
        ready_i = 1'b0;
        flush   = 1'b1;
        #1;
        check("flush_ready_o", 64'(ready_o), 64'd1);
        step();
        flush   = 1'b0;
        valid_i = 1'b0;
        check("flush_count_o", 64'(count_o), 64'd0);
        check("flush_valid_o", 64'(valid_o), 64'd0);
        idle_no_stale(LAT + 3);
`endif

        drain(10);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
